mmio_port_unit: RTL and testbench

Memory-mapped I/O unit downstream of the MIPS processor core's data path. It consumes the core's data-memory request (ALU-computed address, store data, MemWrite/MemRead) and claims three word addresses: an output latch that drives `PortOut`, a debounced and synchronized view of `PortIn`, and a sticky status register. The top level muxes `IOReadData` over the RAM read data whenever `IOHit` is high.

---
 rtl/mmio_port_unit.sv | 168 ++++++++++++++++
 tb/tb_mmio_port_unit.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_port_unit.sv
// mmio_port_unit
// Memory-mapped I/O unit beside the core's data memory. It claims three word
// addresses and returns their contents on IOReadData whenever IOHit is high:
//   BASE_ADDR + 0 : PORT_OUT (R/W) 32-bit output latch driving PortOut
//   BASE_ADDR + 4 : PORT_IN  (RO)  {24'b0, committed} synchronized PortIn
//   BASE_ADDR + 8 : STATUS   (RO)  bit0 IN_CHG, bit1 OUT_WR; sticky, a read clears
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   Address            byte address from the ALU result
//   WriteData          store data
//   MemWrite, MemRead  store / load strobes
//   PortIn             asynchronous external 8-bit input
//   IOHit              Address matches one of the three registers (combinational)
//   IOReadData         read data, 0 when IOHit is low (combinational)
//   PortOut            registered output latch
//
// Build option: define MMIO_DEBOUNCE_EN to insert the debounce FSM between the
// synchronizer and `committed`; otherwise `committed` follows the synchronizer
// directly and DEBOUNCE_CYCLES is ignored.

module mmio_port_unit #(
    parameter logic [31:0] BASE_ADDR       = 32'h1001_0024,
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    input  logic        MemRead,
    input  logic [7:0]  PortIn,
    output logic        IOHit,
    output logic [31:0] IOReadData,
    output logic [31:0] PortOut
);

    localparam logic [31:0] AddrOut  = BASE_ADDR;
    localparam logic [31:0] AddrIn   = BASE_ADDR + 32'd4;
    localparam logic [31:0] AddrStat = BASE_ADDR + 32'd8;

    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 255) begin : g_bad_debounce
        $error("mmio_port_unit: DEBOUNCE_CYCLES must be in 2..255");
    end

    // Address decode: exact word matches only
    logic aligned;
    logic hit_out, hit_in, hit_stat;

    assign aligned  = (Address[1:0] == 2'b00);
    assign hit_out  = aligned && (Address == AddrOut);
    assign hit_in   = aligned && (Address == AddrIn);
    assign hit_stat = aligned && (Address == AddrStat);
    assign IOHit    = hit_out | hit_in | hit_stat;

    logic wr_out, rd_stat;
    assign wr_out  = MemWrite && hit_out;
    assign rd_stat = MemRead && hit_stat;

    logic [31:0] port_out_q, port_out_d;
    logic [7:0]  s1_q, s2_q;
    logic [7:0]  committed_q, committed_d;
    logic        in_chg_q, in_chg_d;
    logic        out_wr_q, out_wr_d;
    logic        in_set;

`ifdef MMIO_DEBOUNCE_EN
    typedef enum logic [0:0] {StIdle, StSettle} state_e;

    localparam logic [7:0] CntTarget = 8'(DEBOUNCE_CYCLES);

    state_e     state_q, state_d;
    logic [7:0] candidate_q, candidate_d;
    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        state_d     = state_q;
        candidate_d = candidate_q;
        cnt_d       = cnt_q;
        committed_d = committed_q;
        in_set      = 1'b0;
        case (state_q)
            StIdle: begin
                if (s2_q != committed_q) begin
                    candidate_d = s2_q;
                    cnt_d       = 8'd1;
                    state_d     = StSettle;
                end
            end
            StSettle: begin
                if (s2_q == committed_q) begin
                    // Input fell back before settling: drop it silently
                    state_d = StIdle;
                    cnt_d   = 8'd0;
                end else if (s2_q != candidate_q) begin
                    candidate_d = s2_q;
                    cnt_d       = 8'd1;
                end else if (cnt_q + 8'd1 == CntTarget) begin
                    committed_d = candidate_q;
                    in_set      = 1'b1;
                    state_d     = StIdle;
                    cnt_d       = 8'd0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            candidate_q <= 8'd0;
            cnt_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            candidate_q <= candidate_d;
            cnt_q       <= cnt_d;
        end
    end
`else
    always_comb begin
        committed_d = s2_q;
        in_set      = (s2_q != committed_q);
    end
`endif

    // A set on the same edge as a read-clear wins
    always_comb begin
        port_out_d = wr_out ? WriteData : port_out_q;
        in_chg_d   = in_set | (in_chg_q & ~rd_stat);
        out_wr_d   = wr_out | (out_wr_q & ~rd_stat);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_out_q  <= 32'd0;
            s1_q        <= 8'd0;
            s2_q        <= 8'd0;
            committed_q <= 8'd0;
            in_chg_q    <= 1'b0;
            out_wr_q    <= 1'b0;
        end else begin
            port_out_q  <= port_out_d;
            s1_q        <= PortIn;
            s2_q        <= s1_q;
            committed_q <= committed_d;
            in_chg_q    <= in_chg_d;
            out_wr_q    <= out_wr_d;
        end
    end

    // Read mux shows pre-edge state, so a STATUS read sees the value before it clears
    always_comb begin
        IOReadData = 32'd0;
        if (hit_out) begin
            IOReadData = port_out_q;
        end else if (hit_in) begin
            IOReadData = {24'd0, committed_q};
        end else if (hit_stat) begin
            IOReadData = {30'd0, out_wr_q, in_chg_q};
        end
    end

    assign PortOut = port_out_q;

endmodule

// File: tb/tb_mmio_port_unit.sv
// Bench for mmio_port_unit: a behavioural model checked every cycle plus
// directed vectors with literal expectations.
module tb_mmio_port_unit;

    localparam logic [31:0] BASE = 32'h1001_0024;
    localparam int unsigned D    = 4;
`ifdef MMIO_DEBOUNCE_EN
    localparam int LAT = 1 + D;
`else
    localparam int LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Address = 32'd0;
    logic [31:0] WriteData = 32'd0;
    logic        MemWrite = 1'b0;
    logic        MemRead = 1'b0;
    logic [7:0]  PortIn = 8'd0;
    logic        IOHit;
    logic [31:0] IOReadData;
    logic [31:0] PortOut;

    int n_tests = 0;
    int n_fail  = 0;

    mmio_port_unit #(
        .BASE_ADDR      (BASE),
        .DEBOUNCE_CYCLES(D)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .Address   (Address),
        .WriteData (WriteData),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .PortIn    (PortIn),
        .IOHit     (IOHit),
        .IOReadData(IOReadData),
        .PortOut   (PortOut)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_port_out = 32'd0;
    logic [7:0]  m_sync0 = 8'd0, m_sync1 = 8'd0;
    logic [7:0]  m_committed = 8'd0;
    logic        m_in_chg = 1'b0, m_out_wr = 1'b0;
    logic [7:0]  m_last = 8'd0;
    int          m_run = 0;

    task automatic model_reset();
        m_port_out  = 32'd0;
        m_sync0     = 8'd0;
        m_sync1     = 8'd0;
        m_committed = 8'd0;
        m_in_chg    = 1'b0;
        m_out_wr    = 1'b0;
        m_last      = 8'd0;
        m_run       = 0;
    endtask

    task automatic model_step();
        logic [7:0] s2;
        logic set_in, set_out, clr;
        s2 = m_sync1;
        set_in = 1'b0;
`ifdef MMIO_DEBOUNCE_EN
        // A new value commits once the synchronized input has held it for D samples
        if (s2 == m_last) m_run++;
        else m_run = 1;
        m_last = s2;
        if (s2 != m_committed && m_run >= int'(D)) begin
            m_committed = s2;
            set_in = 1'b1;
        end
`else
        if (s2 != m_committed) begin
            m_committed = s2;
            set_in = 1'b1;
        end
`endif
        m_sync1 = m_sync0;
        m_sync0 = PortIn;
        set_out = MemWrite && (Address == BASE);
        if (set_out) m_port_out = WriteData;
        clr = MemRead && (Address == BASE + 32'd8);
        m_in_chg = set_in | (m_in_chg & ~clr);
        m_out_wr = set_out | (m_out_wr & ~clr);
    endtask

    function automatic logic exp_hit(input logic [31:0] a);
        return (a == BASE) || (a == BASE + 32'd4) || (a == BASE + 32'd8);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        if (a == BASE) return m_port_out;
        if (a == BASE + 32'd4) return {24'd0, m_committed};
        if (a == BASE + 32'd8) return {30'd0, m_out_wr, m_in_chg};
        return 32'd0;
    endfunction

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) model_reset();
        else model_step();
    end

    // Compare process: outputs checked against the model every cycle
    initial forever begin
        @(negedge clk);
        check("cmp_iohit", {31'd0, IOHit}, {31'd0, exp_hit(Address)});
        check("cmp_rdata", IOReadData, exp_rd(Address));
        check("cmp_portout", PortOut, m_port_out);
    end

    // ---------------- directed stimulus ----------------
    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    // PortIn has just been driven; the next edge is k. Value must appear after edge k+LAT.
    task automatic expect_commit(input string name, input logic [7:0] v, input logic [7:0] old);
        Address  = BASE + 32'd4;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        for (int j = 0; j <= LAT + 2; j++) begin
            cycle();
            #1 check(name, IOReadData, (j >= LAT) ? {24'd0, v} : {24'd0, old});
        end
    endtask

    logic saw_glitch;

    initial begin
        #1 reset = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;
        Address = BASE + 32'd8;
        #1 check("rst_status", IOReadData, 32'd0);
        check("rst_portout", PortOut, 32'd0);
        cycle();

        // Store
        Address = BASE; WriteData = 32'hDEAD_BEEF; MemWrite = 1'b1;
        #1 check("store_pre", IOReadData, 32'd0);
        cycle();
        MemWrite = 1'b0;
        #1 check("store_portout", PortOut, 32'hDEAD_BEEF);
        Address = BASE + 32'd8; MemRead = 1'b1;
        #1 check("store_status", IOReadData, 32'd2);
        cycle();
        #1 check("store_status_clr", IOReadData, 32'd0);
        MemRead = 1'b0;

        // Decode misses
        Address = 32'h1001_0025; WriteData = 32'h1234_5678; MemWrite = 1'b1;
        #1 check("dec_unal_hit", {31'd0, IOHit}, 32'd0);
        check("dec_unal_rd", IOReadData, 32'd0);
        cycle();
        Address = 32'h1001_0030;
        #1 check("dec_far_hit", {31'd0, IOHit}, 32'd0);
        check("dec_far_rd", IOReadData, 32'd0);
        cycle();
        MemWrite = 1'b0; Address = BASE;
        #1 check("dec_portout", PortOut, 32'hDEAD_BEEF);

        // Write and read together on PORT_OUT
        WriteData = 32'hCAFE_F00D; MemWrite = 1'b1; MemRead = 1'b1;
        #1 check("wr_rd_data", IOReadData, 32'hDEAD_BEEF);
        cycle();
        MemWrite = 1'b0; MemRead = 1'b0;
        #1 check("wr_rd_portout", PortOut, 32'hCAFE_F00D);
        Address = BASE + 32'd8; MemRead = 1'b1;
        #1 check("wr_rd_status", IOReadData, 32'd2);
        cycle();
        MemRead = 1'b0;

        // Debounced commit of A5
        PortIn = 8'hA5;
        expect_commit("commit_a5", 8'hA5, 8'h00);
        Address = BASE + 32'd8; MemRead = 1'b1;
        #1 check("commit_status", IOReadData, 32'd1);
        cycle();
        MemRead = 1'b0;

        // Back to 0, then clear IN_CHG
        PortIn = 8'h00;
        expect_commit("fall_00", 8'h00, 8'hA5);
        Address = BASE + 32'd8; MemRead = 1'b1;
        #1 check("fall_status", IOReadData, 32'd1);
        cycle();
        MemRead = 1'b0;

        // Two-clock glitch
        saw_glitch = 1'b0;
        PortIn = 8'h3C;
        Address = BASE + 32'd4;
        for (int j = 0; j < 10; j++) begin
            cycle();
            if (j == 1) PortIn = 8'h00;
            #1 if (IOReadData == 32'h0000_003C) saw_glitch = 1'b1;
        end
        Address = BASE + 32'd8; MemRead = 1'b1;
`ifdef MMIO_DEBOUNCE_EN
        #1 check("glitch_seen", {31'd0, saw_glitch}, 32'd0);
        check("glitch_status", IOReadData, 32'd0);
`else
        #1 check("glitch_seen", {31'd0, saw_glitch}, 32'd1);
        check("glitch_status", IOReadData, 32'd1);
`endif
        cycle();
        MemRead = 1'b0;

        // Read-clear on the commit edge: set wins
        PortIn = 8'h5A;
        Address = BASE + 32'd4;
        repeat (LAT) cycle();
        Address = BASE + 32'd8; MemRead = 1'b1;
        #1 check("coll_pre", IOReadData, 32'd0);
        cycle();
        MemRead = 1'b0;
        #1 check("coll_post", IOReadData, 32'd1);
        MemRead = 1'b1;
        cycle();
        MemRead = 1'b0;
        #1 check("coll_cleared", IOReadData, 32'd0);

        // Reset mid-settle
        PortIn = 8'h77;
        repeat (3) cycle();
        #1 reset = 1'b1;
        #1 check("midrst_portout", PortOut, 32'd0);
        check("midrst_status", IOReadData, 32'd0);
        Address = BASE + 32'd4;
        cycle();
        #1 check("midrst_portin", IOReadData, 32'd0);
        cycle();
        reset = 1'b0;
        expect_commit("post_rst_77", 8'h77, 8'h00);

        cycle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
